// File: rtl/acc_core_mc.sv
// acc_core_mc: multicycle accumulator core, two-word instructions,
// NUM_ACC accumulators, C/Z/N flags, req/ack memory port with wait states.
// Ports: clk, reset (async, low), run, mem_req/we/addr/wdata/rdata/ack,
// pc, flags {C,Z,N}, instr_done pulse, dbg_sel -> dbg_acc debug read.
module acc_core_mc #(
  parameter int DATA_W = 8,
  parameter int NUM_ACC = 4,
  parameter int ADDR_W = 11,
  parameter int unsigned RESET_PC = 0,
  localparam int ACC_W = $clog2(NUM_ACC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        flags,
  output logic              instr_done,
  input  logic [ACC_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_acc
);

  localparam int AH_W = DATA_W - 3 - ACC_W;
  localparam int TG_W = AH_W + DATA_W;

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_STA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_ADC = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_BZ  = 3'd7;

  typedef enum logic [2:0] {
    IDLE, F0, F1, MRD, MWR, EXE, DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] pc_q, pc_inc;
  logic [DATA_W-1:0] ir0, ir1, mdr;
  logic [DATA_W-1:0] acc [NUM_ACC];
  logic              c_q, z_q, n_q;

  logic [2:0]        op;
  logic [ACC_W-1:0]  r;
  logic [TG_W-1:0]   tg_ir, tg_f1;
  logic [ADDR_W-1:0] tgt, tgt_f1;
  logic              take, skip;

  logic [DATA_W-1:0] a, res;
  logic [DATA_W:0]   sum;
  logic              c_n;

  assign op = ir0[DATA_W-1 -: 3];
  assign r  = ir0[DATA_W-4 -: ACC_W];

  // In F1 the second word is still on mem_rdata, so jumps
  // resolve from the bus instead of waiting for IR1.
  assign tg_ir  = {ir0[AH_W-1:0], ir1};
  assign tg_f1  = {ir0[AH_W-1:0], mem_rdata};
  assign tgt    = tg_ir[ADDR_W-1:0];
  assign tgt_f1 = tg_f1[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);

  assign take = (op == OP_JMP) || (op == OP_BZ && z_q);
  assign skip = (op == OP_BZ) && !z_q;

  assign a = acc[r];

  always_comb begin
    res = mdr;
    c_n = c_q;
    sum = '0;
    unique case (op)
      OP_LDA: res = mdr;
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, mdr};
        res = sum[DATA_W-1:0];
        c_n = sum[DATA_W];
      end
      OP_ADC: begin
        sum = {1'b0, a} + {1'b0, mdr}
            + {{DATA_W{1'b0}}, c_q};
        res = sum[DATA_W-1:0];
        c_n = sum[DATA_W];
      end
      OP_SUB: begin
        sum = {1'b0, a} - {1'b0, mdr};
        res = sum[DATA_W-1:0];
        c_n = ~sum[DATA_W];
      end
      OP_AND: res = a & mdr;
      default: res = mdr;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (run) state_n = F0;
      F0:   if (mem_ack) state_n = F1;
      F1: if (mem_ack) begin
        unique case (1'b1)
          take, skip:     state_n = DONE;
          (op == OP_STA): state_n = MWR;
          default:        state_n = MRD;
        endcase
      end
      MRD:  if (mem_ack) state_n = EXE;
      EXE:  state_n = DONE;
      MWR:  if (mem_ack) state_n = DONE;
      DONE: state_n = run ? F0 : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= ADDR_W'(RESET_PC);
      ir0  <= '0;
      ir1  <= '0;
      mdr  <= '0;
      c_q  <= 1'b0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      for (int i = 0; i < NUM_ACC; i++)
        acc[i] <= '0;
    end else begin
      case (state)
        F0: if (mem_ack) begin
          ir0  <= mem_rdata;
          pc_q <= pc_inc;
        end
        F1: if (mem_ack) begin
          ir1  <= mem_rdata;
          pc_q <= take ? tgt_f1 : pc_inc;
        end
        MRD: if (mem_ack) mdr <= mem_rdata;
        EXE: begin
          acc[r] <= res;
          c_q    <= c_n;
          z_q    <= (res == '0);
          n_q    <= res[DATA_W-1];
        end
        default: ;
      endcase
    end
  end

  assign mem_req = (state == F0) || (state == F1)
                || (state == MRD) || (state == MWR);
  assign mem_we    = (state == MWR);
  assign mem_addr  = (state == F0 || state == F1)
                   ? pc_q : tgt;
  assign mem_wdata = a;

  assign pc         = pc_q;
  assign flags      = {c_q, z_q, n_q};
  assign instr_done = (state == DONE);
  assign dbg_acc    = acc[dbg_sel];

endmodule

// File: tb/tb_acc_core_mc.sv
// tb_acc_core_mc: directed and random programs for acc_core_mc,
// checked against an instruction-level reference model.
module tb_acc_core_mc;

  logic        clk = 1'b0;
  logic        rst_n, run, run2;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [10:0] mem_addr, pc;
  logic [7:0]  mem_wdata, mem_rdata = 8'h00, dbg_acc;
  logic [2:0]  flags;
  logic        instr_done;
  logic [1:0]  dbg_sel;

  logic        req2, we2, ack2, done2;
  logic [10:0] addr2, pc2;
  logic [7:0]  wdata2, rdata2, dbg_acc2;
  logic [2:0]  flags2;
  logic [1:0]  dbg_sel2;

  logic [7:0]  mem  [2048];
  logic [7:0]  mem2 [2048];
  logic [7:0]  m_mem [2048];

  always #5 clk = ~clk;

  acc_core_mc u_dut (
    .clk(clk), .reset(rst_n), .run(run),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .flags(flags), .instr_done(instr_done),
    .dbg_sel(dbg_sel), .dbg_acc(dbg_acc)
  );

  acc_core_mc #(.RESET_PC(11'h7FF)) u_wrap (
    .clk(clk), .reset(rst_n), .run(run2),
    .mem_req(req2), .mem_we(we2),
    .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_rdata(rdata2), .mem_ack(ack2),
    .pc(pc2), .flags(flags2), .instr_done(done2),
    .dbg_sel(dbg_sel2), .dbg_acc(dbg_acc2)
  );

  assign ack2   = req2;
  assign rdata2 = mem2[addr2];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // memory responder: fixed wait count per access
  int          wait_n = 0, wcnt = 0;
  int          stab_err = 0, wr_cnt = 0, last_len = 0;
  logic [10:0] s_addr, wa;
  logic [7:0]  s_wdata, wd;
  logic        s_we;

  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      wcnt      = 0;
    end else begin
      if (wcnt == 0) begin
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wdata = mem_wdata;
      end else if (mem_addr != s_addr || mem_we != s_we
                   || (mem_we && mem_wdata != s_wdata))
        stab_err++;
      if (wcnt >= wait_n) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) begin
          wr_cnt++;
          wa       = mem_addr;
          wd       = mem_wdata;
          last_len = wcnt + 1;
        end
        wcnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wcnt++;
      end
    end
  end

  logic [10:0] f_addr [2];
  int          f_n = 0;
  always @(negedge clk)
    if (req2 && f_n < 2) begin
      f_addr[f_n] = addr2;
      f_n++;
    end

  int errs = 0, checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // reference model state
  int         m_pc, chain, last_cyc, wr_seen;
  logic [7:0] m_acc [4];
  logic       m_c, m_z, m_n;
  logic [7:0] obs_acc [4];

  task automatic start(input int w);
    rst_n  = 1'b0;
    run    = 1'b0;
    wait_n = w;
    @(negedge clk);
    m_pc    = 0;
    m_acc   = '{default: 8'h00};
    m_c     = 1'b0;
    m_z     = 1'b0;
    m_n     = 1'b0;
    m_mem   = mem;
    wr_seen = wr_cnt;
    chain   = 0;
    rst_n   = 1'b1;
    run     = 1'b1;
  endtask

  task automatic halt();
    run   = 1'b0;
    chain = 0;
  endtask

  task automatic wait_done();
    int k, w0, w1, op, r, tg, s, lat, exp_wr;
    k = 0;
    @(negedge clk);
    while (!instr_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", instr_done, 1);
    if (!instr_done) return;
    w0 = m_mem[m_pc];
    w1 = m_mem[(m_pc + 1) % 2048];
    op = w0 / 32;
    r  = (w0 / 8) % 4;
    tg = (w0 % 8) * 256 + w1;
    m_pc = (m_pc + 2) % 2048;
    exp_wr = 0;
    case (op)
      0: m_acc[r] = m_mem[tg];
      1: begin
        exp_wr    = 1;
        m_mem[tg] = m_acc[r];
      end
      2, 3: begin
        s = m_acc[r] + m_mem[tg];
        if (op == 3) s = s + m_c;
        m_c      = (s > 255);
        m_acc[r] = 8'(s);
      end
      4: begin
        m_c      = (m_acc[r] >= m_mem[tg]);
        m_acc[r] = m_acc[r] - m_mem[tg];
      end
      5: m_acc[r] = m_acc[r] & m_mem[tg];
      6: m_pc = tg;
      default: if (m_z) m_pc = tg;
    endcase
    if (op != 1 && op < 6) begin
      m_z = (m_acc[r] == 8'h00);
      m_n = m_acc[r][7];
    end
    if (op >= 6)      lat = 3 + 2 * wait_n;
    else if (op == 1) lat = 4 + 3 * wait_n;
    else              lat = 5 + 3 * wait_n;
    if (chain != 0) chk("lat", cyc - last_cyc, lat);
    last_cyc = cyc;
    chk("pc", pc, m_pc);
    chk("flags", flags, {m_c, m_z, m_n});
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      obs_acc[i] = dbg_acc;
      chk($sformatf("acc%0d", i), dbg_acc, m_acc[i]);
    end
    chk("wr_cnt", wr_cnt - wr_seen, exp_wr);
    if (exp_wr != 0) begin
      chk("wr_addr", wa, tg);
      chk("wr_data", wd, m_mem[tg]);
    end
    if (wr_cnt != wr_seen) mem[wa] = wd;
    wr_seen = wr_cnt;
    chain   = run ? 1 : 0;
  endtask

  task automatic wait_req(input logic [10:0] a);
    int k;
    k = 0;
    @(negedge clk);
    while (!(mem_req && mem_addr == a) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", mem_req && mem_addr == a, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int op, rr, tg, k, seen, base;
    rst_n = 1'b0;
    run   = 1'b1;
    run2  = 1'b0;
    dbg_sel  = 2'd0;
    dbg_sel2 = 2'd0;
    for (int i = 0; i < 2048; i++) begin
      mem[i]  = 8'h00;
      mem2[i] = 8'h00;
    end
    repeat (3) @(negedge clk);

    chk("rst_pc", pc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_pc2", pc2, 11'h7FF);
    rst_n = 1'b1;
    #1;
    chk("rel_req", mem_req, 0);

    mem[0] = 8'h09; mem[1] = 8'h00;
    mem[2] = 8'h49; mem[3] = 8'h01;
    mem[11'h100] = 8'h7F; mem[11'h101] = 8'h01;
    start(0);
    wait_done();
    wait_done();
    halt();
    chk("t2_acc1", obs_acc[1], 8'h80);
    chk("t2_flags", flags, 3'b001);

    mem[0] = 8'h01; mem[1] = 8'h00;
    mem[2] = 8'h81; mem[3] = 8'h00;
    mem[4] = 8'hE0; mem[5] = 8'h20;
    mem[11'h100] = 8'h33;
    mem[11'h020] = 8'h01; mem[11'h021] = 8'h01;
    mem[11'h022] = 8'hE0; mem[11'h023] = 8'h40;
    mem[11'h101] = 8'h01;
    start(1);
    wait_done();
    wait_done();
    chk("t3_acc0", obs_acc[0], 8'h00);
    chk("t3_flags", flags, 3'b110);
    wait_done();
    chk("t3_bz_taken", pc, 11'h020);
    wait_done();
    wait_done();
    chk("t3_bz_fall", pc, 11'h024);
    halt();

    mem[0] = 8'h11; mem[1] = 8'h02;
    mem[2] = 8'h31; mem[3] = 8'h10;
    mem[11'h102] = 8'hA5;
    start(3);
    base = wr_cnt;
    wait_done();
    wait_done();
    halt();
    chk("t4_len", last_len, 4);
    chk("t4_wdata", wd, 8'hA5);
    chk("t4_writes", wr_cnt - base, 1);

    mem2[11'h7FF] = 8'h00;
    mem2[11'h000] = 8'h10;
    mem2[11'h010] = 8'h5A;
    @(negedge clk);
    run2 = 1'b1;
    k = 0;
    @(negedge clk);
    while (!done2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    run2 = 1'b0;
    chk("t5_done", done2, 1);
    chk("t5_f0", f_addr[0], 11'h7FF);
    chk("t5_f1", f_addr[1], 11'h000);
    chk("t5_pc", pc2, 11'h001);
    #1;
    chk("t5_acc", dbg_acc2, 8'h5A);

    mem[0] = 8'h19; mem[1] = 8'h00;
    mem[2] = 8'h11; mem[3] = 8'h01;
    mem[4] = 8'h01; mem[5] = 8'h02;
    mem[11'h100] = 8'h3C;
    mem[11'h101] = 8'hC3;
    mem[11'h102] = 8'h77;
    start(2);
    wait_done();
    wait_req(11'h101);
    run = 1'b0;
    wait_done();
    chk("t6_acc2", obs_acc[2], 8'hC3);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req || instr_done) seen++;
    end
    chk("t6_idle", seen, 0);
    run = 1'b1;
    wait_req(11'h102);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_pc", pc, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("t6_clr%0d", i), dbg_acc, 8'h00);
    end

    for (int t = 0; t < 3; t++) begin
      for (int ad = 0; ad < 11'h3FE; ad += 2) begin
        op = $urandom_range(0, 7);
        rr = $urandom_range(0, 3);
        if (op >= 6) tg = 2 * $urandom_range(0, 11'h1FF);
        else         tg = $urandom_range(11'h400, 11'h7FF);
        mem[ad]     = 8'(op * 32 + rr * 8 + tg / 256);
        mem[ad + 1] = 8'(tg % 256);
      end
      mem[11'h3FE] = 8'hC0;
      mem[11'h3FF] = 8'h00;
      for (int ad = 11'h400; ad < 2048; ad++)
        mem[ad] = 8'($urandom);
      start(t);
      repeat (60) wait_done();
      halt();
    end

    chk("stable", stab_err, 0);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
